bubble_timing_gen_param: RTL and testbench



---
 rtl/bubble_timing_gen_param.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_bubble_timing_gen_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bubble_timing_gen_param.sv
// bubble_timing_gen_param
//   Parametrised bubble-memory timing generator. Divides MCLK down to the host
//   CLKOUT, synchronises the asynchronous host strobes, tracks the access mode
//   and produces the quarter-cycle field phase, the absolute loop position and
//   the output-bit cycle number.
//
// Ports
//   MCLK            master clock, all logic on posedge
//   RST             synchronous active-high reset
//   CLKOUT          MCLK divided by 2*CLKDIV_HALF, 50% duty
//   nINCTRL         input-control enable, async, low active
//   nBSS, nBSEN, nREPEN, nBOOTEN   host strobes, async
//   ACCTYPE         access mode: RST 000, STBY 001, IDLE 100, BOOT 110, USER 111
//   BOUTCYCLENUM    output bit cycle number, all-ones when no valid bit
//   BOUTTICKS       quarter index (+X,-X,-Y,+Y) of the last field quarter,
//                   2'b11 while rotation is stopped
//   ABSPOS          absolute loop position, wraps POS_COUNT-1 -> 0
//   PAGEDONE        one-MCLK pulse on page completion and on bootloader wrap
//
// Build option
//   TG_DONE_PULSE_EN  defined: PAGEDONE generated. Undefined: PAGEDONE tied 0.
module bubble_timing_gen_param #(
  parameter int unsigned CLKDIV_HALF = 6,
  parameter int unsigned SYNC_STAGES = 4,
  parameter int unsigned CYCLE_CLKS  = 480,
  parameter int unsigned START_OFF   = 88,
  parameter int unsigned POS_COUNT   = 2053,
  parameter int unsigned INIT_POS    = 2051,
  parameter int unsigned POS_W       = 12,
  parameter int unsigned SKIP_CYCLES = 98,
  parameter int unsigned BOOT_BITS   = 4106,
  parameter int unsigned PAGE_BITS   = 584,
  parameter int unsigned CYC_W       = 13
) (
  input  logic             MCLK,
  input  logic             RST,
  output logic             CLKOUT,
  input  logic             nINCTRL,
  input  logic             nBSS,
  input  logic             nBSEN,
  input  logic             nREPEN,
  input  logic             nBOOTEN,
  output logic [2:0]       ACCTYPE,
  output logic [CYC_W-1:0] BOUTCYCLENUM,
  output logic [1:0]       BOUTTICKS,
  output logic [POS_W-1:0] ABSPOS,
  output logic             PAGEDONE
);

  localparam int unsigned QUARTER = CYCLE_CLKS / 4;
  localparam int unsigned PH_W    = $clog2(START_OFF + CYCLE_CLKS + 1);
  localparam int unsigned DIV_W   = (CLKDIV_HALF > 1) ? $clog2(CLKDIV_HALF) : 1;
  localparam int unsigned SKIP_Q  = SKIP_CYCLES * 4;
  localparam int unsigned BOOT_Q  = BOOT_BITS * 4;
  localparam int unsigned PAGE_Q  = PAGE_BITS * 4;
  localparam int unsigned CNT_MAX = (BOOT_Q > PAGE_Q) ?
                                    ((BOOT_Q > SKIP_Q) ? BOOT_Q : SKIP_Q) :
                                    ((PAGE_Q > SKIP_Q) ? PAGE_Q : SKIP_Q);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [PH_W-1:0]  PH_Q0     = PH_W'(START_OFF);
  localparam logic [PH_W-1:0]  PH_Q1     = PH_W'(START_OFF + QUARTER);
  localparam logic [PH_W-1:0]  PH_Q2     = PH_W'(START_OFF + 2 * QUARTER);
  localparam logic [PH_W-1:0]  PH_Q3     = PH_W'(START_OFF + 3 * QUARTER);
  localparam logic [PH_W-1:0]  PH_Q4     = PH_W'(START_OFF + CYCLE_CLKS);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKDIV_HALF - 1);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(POS_COUNT - 1);
  localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(SKIP_Q - 1);
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_Q - 1);
  localparam logic [CNT_W-1:0] PAGE_LAST = CNT_W'(PAGE_Q - 1);

  typedef enum logic [2:0] {
    ACC_RST  = 3'b000,
    ACC_STBY = 3'b001,
    ACC_IDLE = 3'b100,
    ACC_BOOT = 3'b110,
    ACC_USER = 3'b111
  } acc_e;

  typedef enum logic [1:0] {
    XF_OFF,
    XF_SKIP,
    XF_XFER,
    XF_DONE
  } xfer_e;

  logic [DIV_W-1:0] div_q, div_d;
  logic             clkout_q, clkout_d;
  logic [3:0]       sync_q [SYNC_STAGES];
  logic [3:0]       sync_d [SYNC_STAGES];
  acc_e             acc_q, acc_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [1:0]       ticks_q, ticks_d;
  xfer_e            xf_q, xf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       key;
  logic             qe;
  logic [1:0]       qk;

  // Clock divider
  always_comb begin
    div_d    = div_q + DIV_W'(1);
    clkout_d = clkout_q;
    if (div_q == DIV_LAST) begin
      div_d    = '0;
      clkout_d = ~clkout_q;
    end
  end

  // Synchroniser: all four strobes travel through the same chain so that a
  // combined key change is seen by the access FSM in a single cycle.
  always_comb begin
    sync_d[0] = {nINCTRL | nBSS,
                 nINCTRL | nBSEN,
                 nINCTRL | nREPEN | ~nBOOTEN,
                 ~nINCTRL & nBOOTEN};
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Key order {BOOTEN, BSS, BSEN, REPEN}
  assign key = {sync_q[SYNC_STAGES-1][0], sync_q[SYNC_STAGES-1][3],
                sync_q[SYNC_STAGES-1][2], sync_q[SYNC_STAGES-1][1]};

  // Access mode FSM
  always_comb begin
    acc_d = acc_q;
    case (key)
      4'b1011, 4'b1111: acc_d = (acc_q == ACC_STBY) ? ACC_STBY : ACC_RST;
      4'b0011, 4'b0111: if (acc_q == ACC_RST) acc_d = ACC_STBY;
      4'b1001: if (acc_q == ACC_STBY || acc_q == ACC_BOOT) acc_d = ACC_BOOT;
      4'b1101: if (acc_q == ACC_STBY) acc_d = ACC_IDLE;
      4'b1100: if (acc_q == ACC_IDLE) acc_d = ACC_USER;
      default: ;
    endcase
  end

  assign ACCTYPE = acc_q;

  // Quarter-point decode; Q(4) closes the cycle and is quarter 0 again.
  always_comb begin
    qe = 1'b0;
    qk = 2'b00;
    if (ph_q == PH_Q0 || ph_q == PH_Q4) begin
      qe = 1'b1;
      qk = 2'd0;
    end else if (ph_q == PH_Q1) begin
      qe = 1'b1;
      qk = 2'd1;
    end else if (ph_q == PH_Q2) begin
      qe = 1'b1;
      qk = 2'd2;
    end else if (ph_q == PH_Q3) begin
      qe = 1'b1;
      qk = 2'd3;
    end
  end

  // Phase counter, loop position and quarter index. Rotation only stops at
  // Q(1), so a field that has started always completes its current quarter.
  always_comb begin
    ph_d    = ph_q + PH_W'(1);
    pos_d   = pos_q;
    ticks_d = ticks_q;
    if (ph_q == '0) begin
      ph_d = ACCTYPE[2] ? PH_W'(1) : '0;
    end else if (ph_q == PH_Q1 && !ACCTYPE[2]) begin
      ph_d = '0;
    end else if (ph_q == PH_Q4) begin
      ph_d = PH_Q0 + PH_W'(1);
    end
    if (ph_q == PH_Q4) begin
      pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
    end
    if (ph_q == '0) begin
      ticks_d = 2'b11;
    end else if (qe) begin
      ticks_d = qk;
    end
  end

  assign ABSPOS    = pos_q;
  assign BOUTTICKS = (ph_q == '0) ? 2'b11 : ticks_q;

  // Transfer FSM, advanced once per quarter. A single counter is reused for
  // the skip window and for the transfer quarter count.
  always_comb begin
    xf_d  = xf_q;
    cnt_d = cnt_q;
    if (qe) begin
      if (ph_q == '0 || !ACCTYPE[1]) begin
        xf_d  = XF_OFF;
        cnt_d = '0;
      end else begin
        case (xf_q)
          XF_OFF: begin
            xf_d  = XF_SKIP;
            cnt_d = '0;
          end
          XF_SKIP: begin
            if (cnt_q == SKIP_LAST) begin
              xf_d  = XF_XFER;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          XF_XFER: begin
            if (ACCTYPE[0]) begin
              if (cnt_q == PAGE_LAST) xf_d = XF_DONE;
              else                    cnt_d = cnt_q + CNT_W'(1);
            end else begin
              cnt_d = (cnt_q == BOOT_LAST) ? '0 : cnt_q + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    BOUTCYCLENUM = '1;
    case (xf_q)
      XF_XFER: BOUTCYCLENUM = CYC_W'(cnt_q >> 2);
      XF_DONE: BOUTCYCLENUM = CYC_W'(PAGE_BITS - 1);
      default: ;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (RST) begin
      div_q    <= '0;
      clkout_q <= 1'b1;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 4'b1110;
      end
      acc_q    <= ACC_RST;
      ph_q     <= '0;
      pos_q    <= POS_W'(INIT_POS);
      ticks_q  <= 2'b11;
      xf_q     <= XF_OFF;
      cnt_q    <= '0;
    end else begin
      div_q    <= div_d;
      clkout_q <= clkout_d;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      acc_q    <= acc_d;
      ph_q     <= ph_d;
      pos_q    <= pos_d;
      ticks_q  <= ticks_d;
      xf_q     <= xf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign CLKOUT = clkout_q;

`ifdef TG_DONE_PULSE_EN
  logic pagedone_q, pagedone_d;

  // Fires on the quarter that ends the page or wraps the bootloader stream.
  always_comb begin
    pagedone_d = 1'b0;
    if (qe && (ph_q != '0) && ACCTYPE[1] && (xf_q == XF_XFER)) begin
      pagedone_d = ACCTYPE[0] ? (cnt_q == PAGE_LAST) : (cnt_q == BOOT_LAST);
    end
  end

  always_ff @(posedge MCLK) begin
    if (RST) pagedone_q <= 1'b0;
    else     pagedone_q <= pagedone_d;
  end

  assign PAGEDONE = pagedone_q;
`else
  assign PAGEDONE = 1'b0;
`endif

endmodule

// File: tb/tb_bubble_timing_gen_param.sv
// Testbench for bubble_timing_gen_param. A reduced-geometry instance runs
// randomized host-strobe episodes against a behavioural model; a default
// instance shares the stimulus for reset values and divider checks.
module tb_bubble_timing_gen_param;

  localparam int T_HALF  = 3;
  localparam int T_SYNC  = 3;
  localparam int T_CYCLE = 16;
  localparam int T_START = 5;
  localparam int T_POSC  = 7;
  localparam int T_INIT  = 5;
  localparam int T_POSW  = 3;
  localparam int T_SKIP  = 3;
  localparam int T_BOOT  = 5;
  localparam int T_PAGE  = 4;
  localparam int T_CYCW  = 4;
  localparam int T_QTR   = T_CYCLE / 4;
  localparam int T_ALL1  = (1 << T_CYCW) - 1;
`ifdef TG_DONE_PULSE_EN
  localparam bit PD_EN = 1'b1;
`else
  localparam bit PD_EN = 1'b0;
`endif

  logic MCLK, RST, nINCTRL, nBSS, nBSEN, nREPEN, nBOOTEN;

  logic              clkout, pagedone;
  logic [2:0]        acctype;
  logic [T_CYCW-1:0] cyc;
  logic [1:0]        ticks;
  logic [T_POSW-1:0] abspos;

  logic        d_clkout, d_pagedone;
  logic [2:0]  d_acctype;
  logic [12:0] d_cyc;
  logic [1:0]  d_ticks;
  logic [11:0] d_abspos;

  bubble_timing_gen_param #(
    .CLKDIV_HALF(T_HALF), .SYNC_STAGES(T_SYNC), .CYCLE_CLKS(T_CYCLE),
    .START_OFF(T_START), .POS_COUNT(T_POSC), .INIT_POS(T_INIT), .POS_W(T_POSW),
    .SKIP_CYCLES(T_SKIP), .BOOT_BITS(T_BOOT), .PAGE_BITS(T_PAGE), .CYC_W(T_CYCW)
  ) u_dut (
    .MCLK(MCLK), .RST(RST), .CLKOUT(clkout), .nINCTRL(nINCTRL), .nBSS(nBSS),
    .nBSEN(nBSEN), .nREPEN(nREPEN), .nBOOTEN(nBOOTEN), .ACCTYPE(acctype),
    .BOUTCYCLENUM(cyc), .BOUTTICKS(ticks), .ABSPOS(abspos), .PAGEDONE(pagedone)
  );

  bubble_timing_gen_param u_dut_def (
    .MCLK(MCLK), .RST(RST), .CLKOUT(d_clkout), .nINCTRL(nINCTRL), .nBSS(nBSS),
    .nBSEN(nBSEN), .nREPEN(nREPEN), .nBOOTEN(nBOOTEN), .ACCTYPE(d_acctype),
    .BOUTCYCLENUM(d_cyc), .BOUTTICKS(d_ticks), .ABSPOS(d_abspos), .PAGEDONE(d_pagedone)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [3:0] m_sync[$];
  logic [2:0] m_acc;
  int         m_ph, m_pos, m_ticks, m_nq, m_n;
  bit         m_on, m_user, m_pd;

  logic [3:0] mv_s;
  logic [2:0] mv_acc;
  int         mv_k, mv_q;

  // Quarter index of a phase value, -1 when not a quarter point.
  function automatic int quarter_of(input int ph);
    if (ph < T_START || (ph - T_START) % T_QTR != 0 || (ph - T_START) / T_QTR > 4) return -1;
    return ((ph - T_START) / T_QTR) % 4;
  endfunction

  function automatic logic [2:0] next_acc(input logic [2:0] a, input logic [3:0] key);
    case (key)
      4'b1011, 4'b1111: return (a == 3'b001) ? 3'b001 : 3'b000;
      4'b0011, 4'b0111: return (a == 3'b000) ? 3'b001 : a;
      4'b1001: return (a == 3'b001 || a == 3'b110) ? 3'b110 : a;
      4'b1101: return (a == 3'b001) ? 3'b100 : a;
      4'b1100: return (a == 3'b100) ? 3'b111 : a;
      default: return a;
    endcase
  endfunction

  function automatic int exp_cyc();
    int q;
    if (!m_on) return T_ALL1;
    q = m_nq - 4 * T_SKIP;
    if (q < 0) return T_ALL1;
    if (m_user) return (q / 4 > T_PAGE - 1) ? T_PAGE - 1 : q / 4;
    return (q / 4) % T_BOOT;
  endfunction

  always @(posedge MCLK) begin
    if (RST) begin
      m_sync.delete();
      for (int unsigned i = 0; i < T_SYNC; i++) m_sync.push_back(4'b1110);
      m_acc = 3'b000; m_ph = 0; m_pos = T_INIT; m_ticks = 3;
      m_on = 1'b0; m_user = 1'b0; m_nq = 0; m_pd = 1'b0; m_n = 0;
    end else begin
      mv_s = m_sync.pop_front();
      m_sync.push_back({nINCTRL | nBSS, nINCTRL | nBSEN,
                        nINCTRL | nREPEN | ~nBOOTEN, ~nINCTRL & nBOOTEN});
      mv_acc = m_acc;
      mv_k   = quarter_of(m_ph);
      if (m_ph == T_START + T_CYCLE) m_pos = (m_pos + 1) % T_POSC;
      if (m_ph == 0) m_ticks = 3;
      else if (mv_k >= 0) m_ticks = mv_k;
      m_pd = 1'b0;
      if (mv_k >= 0) begin
        if (m_ph == 0 || !mv_acc[1]) begin
          m_on = 1'b0;
        end else if (!m_on) begin
          m_on = 1'b1; m_user = mv_acc[0]; m_nq = 0;
        end else begin
          mv_q = m_nq - 4 * T_SKIP;
          if (mv_q >= 0) begin
            if (m_user && mv_q == 4 * T_PAGE - 1) m_pd = 1'b1;
            if (!m_user && mv_q % (4 * T_BOOT) == 4 * T_BOOT - 1) m_pd = 1'b1;
          end
          m_nq++;
        end
      end
      if (m_ph == 0) m_ph = mv_acc[2] ? 1 : 0;
      else if (m_ph == T_START + T_QTR && !mv_acc[2]) m_ph = 0;
      else if (m_ph == T_START + T_CYCLE) m_ph = T_START + 1;
      else m_ph++;
      m_acc = next_acc(mv_acc, {mv_s[0], mv_s[3], mv_s[2], mv_s[1]});
      m_n++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_all();
    check_eq("acctype", acctype, m_acc);
    check_eq("cyclenum", cyc, exp_cyc());
    check_eq("ticks", ticks, (m_ph == 0) ? 3 : m_ticks);
    check_eq("abspos", abspos, m_pos);
    check_eq("clkout", clkout, 1 ^ ((m_n / T_HALF) % 2));
    check_eq("pagedone", pagedone, PD_EN ? m_pd : 1'b0);
    check_eq("def_clkout", d_clkout, 1 ^ ((m_n / 6) % 2));
  endtask

  task automatic run(input int unsigned n);
    repeat (n) begin
      @(negedge MCLK);
      check_all();
    end
  endtask

  task automatic drive(input logic inctrl, input logic bss, input logic bsen,
                       input logic repen, input logic booten);
    nINCTRL = inctrl; nBSS = bss; nBSEN = bsen; nREPEN = repen; nBOOTEN = booten;
  endtask

  task automatic episode(input int unsigned kind);
    case (kind)
      0: begin  // input control off: key 0111
        drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        run($urandom_range(8, 20));
      end
      1: begin  // bootloader: key 1001
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        run($urandom_range(150, 400));
      end
      2: begin  // page: 1101, REPEN pulse 1100, back to 1101
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        run($urandom_range(4, 10));
        nREPEN = 1'b0;
        run($urandom_range(1, 4));
        nREPEN = 1'b1;
        run($urandom_range(40, 260));
      end
      3: begin  // BSEN released: key 1111
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        run($urandom_range(10, 40));
      end
      4: begin
        repeat ($urandom_range(20, 60)) begin
          drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
          run(1);
        end
      end
      default: begin
        RST = 1'b1;
        run($urandom_range(1, 3));
        RST = 1'b0;
        run(2);
      end
    endcase
  endtask

  initial begin
    RST = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge MCLK);
    check_eq("rst_def_clkout", d_clkout, 1);
    check_eq("rst_def_acctype", d_acctype, 0);
    check_eq("rst_def_abspos", d_abspos, 2051);
    check_eq("rst_def_cyclenum", d_cyc, 8191);
    check_eq("rst_def_ticks", d_ticks, 3);
    check_eq("rst_def_pagedone", d_pagedone, 0);
    check_all();
    RST = 1'b0;
    episode(0); episode(1); episode(3);
    episode(0); episode(2); episode(3);
    episode(0); episode(2); episode(5);
    episode(0); episode(1); episode(5);
    for (int unsigned i = 0; i < 50; i++) episode($urandom_range(0, 5));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
